// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and constants for the receive and read paths.
// Contents: receiver FSM state enum, data-bit count, default clock/baud rates.
// No ports; imported with "import uart_pkg::*;".
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int CLK_FREQ_DEF   = 50_000_000;
  localparam int BAUD_RATE_DEF  = 9600;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART byte receiver with 2-FF synchroniser and mid-bit sampling.
// Ports: s_clk/s_rst (async active-high), rs232_rx line in; rx_byte, one-cycle
//        rx_byte_valid per good byte, one-cycle frame_err when the stop bit samples low.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int BAUD_MAX = CLK_FREQ_DEF / BAUD_RATE_DEF,
  parameter int BAUD_MID = BAUD_MAX / 2
) (
  input  logic                      s_clk,
  input  logic                      s_rst,
  input  logic                      rs232_rx,
  output logic [UART_DATA_BITS-1:0] rx_byte,
  output logic                      rx_byte_valid,
  output logic                      frame_err
);

  // BAUD_MAX must be >= 4 and BAUD_MID < BAUD_MAX for the sample point to exist.
  localparam int CNT_W = $clog2(BAUD_MAX);
  localparam int BIT_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] C_MID  = CNT_W'(BAUD_MID);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(BAUD_MAX - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] B_LAST = BIT_W'(UART_DATA_BITS - 1);
  localparam logic [BIT_W-1:0] B_ONE  = BIT_W'(1);

  logic                      r_sync1;
  logic                      r_sync2;
  logic                      r_prev;
  uart_state_t               r_state;
  logic [CNT_W-1:0]          r_baud_cnt;
  logic [BIT_W-1:0]          r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_rx_byte;
  logic                      r_rx_byte_valid;
  logic                      r_frame_err;

  logic w_line;
  logic w_fall;
  logic w_sample;
  logic w_wrap;

  // Synchroniser and edge-detect flops idle high so reset never fakes a start edge.
  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= rs232_rx;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_line   = r_sync2;
  assign w_fall   = r_prev & ~r_sync2;
  assign w_sample = (r_baud_cnt == C_MID);
  assign w_wrap   = (r_baud_cnt == C_LAST);

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_state         <= ST_IDLE;
      r_baud_cnt      <= '0;
      r_bit_cnt       <= '0;
      r_shift         <= '0;
      r_rx_byte       <= '0;
      r_rx_byte_valid <= 1'b0;
      r_frame_err     <= 1'b0;
    end else begin
      r_rx_byte_valid <= 1'b0;
      r_frame_err     <= 1'b0;
      if (r_state != ST_IDLE) begin
        r_baud_cnt <= w_wrap ? '0 : r_baud_cnt + C_ONE;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_baud_cnt <= '0;
            r_state    <= ST_START;
          end
        end
        ST_START: begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (w_sample && w_line) begin
            r_state <= ST_IDLE;
          end else if (w_wrap) begin
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_sample) begin
            r_shift <= {w_line, r_shift[UART_DATA_BITS-1:1]};
          end
          if (w_wrap) begin
            if (r_bit_cnt == B_LAST) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + B_ONE;
            end
          end
        end
        ST_STOP: begin
          // Leave at mid stop bit so a back-to-back start edge is not missed.
          if (w_sample) begin
            if (w_line) begin
              r_rx_byte       <= r_shift;
              r_rx_byte_valid <= 1'b1;
              r_state         <= ST_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_BREAK;
            end
          end
        end
        ST_BREAK: begin
          // Wait for the line to return high; no start edge can be seen until then.
          if (w_line) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_byte       = r_rx_byte;
  assign rx_byte_valid = r_rx_byte_valid;
  assign frame_err     = r_frame_err;

endmodule

// File: rtl/uart_rx_word.sv
// uart_rx_word: UART receive front end packing byte pairs into 16-bit words.
// Ports: s_clk/s_rst, rs232_rx, flush in; m_data/m_valid/m_ready word handshake,
//        rx_byte/rx_byte_valid debug, frame_err and overflow one-cycle pulses.
module uart_rx_word
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEF,
  parameter int BAUD_RATE = BAUD_RATE_DEF,
  parameter int BAUD_MAX  = CLK_FREQ / BAUD_RATE,
  parameter int BAUD_MID  = BAUD_MAX / 2
) (
  input  logic        s_clk,
  input  logic        s_rst,
  input  logic        rs232_rx,
  input  logic        flush,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  rx_byte,
  output logic        rx_byte_valid,
  output logic        frame_err,
  output logic        overflow
);

  logic [UART_DATA_BITS-1:0] w_rx_byte;
  logic                      w_rx_vld;
  logic                      w_frame_err;
  logic                      w_accept;

  logic                      r_phase;
  logic [UART_DATA_BITS-1:0] r_lo;
  logic [15:0]               r_m_data;
  logic                      r_m_valid;
  logic                      r_overflow;

  uart_rx_byte #(
    .BAUD_MAX (BAUD_MAX),
    .BAUD_MID (BAUD_MID)
  ) u_rx_byte (
    .s_clk         (s_clk),
    .s_rst         (s_rst),
    .rs232_rx      (rs232_rx),
    .rx_byte       (w_rx_byte),
    .rx_byte_valid (w_rx_vld),
    .frame_err     (w_frame_err)
  );

  assign w_accept = r_m_valid & m_ready;

  always_ff @(posedge s_clk or posedge s_rst) begin
    if (s_rst) begin
      r_phase    <= 1'b0;
      r_lo       <= '0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_overflow <= 1'b0;
      if (w_accept) begin
        r_m_valid <= 1'b0;
      end
      // flush beats a coincident byte: both the stored low byte and the new byte go.
      if (flush) begin
        r_phase <= 1'b0;
        r_lo    <= '0;
      end else if (w_rx_vld) begin
        if (!r_phase) begin
          r_lo    <= w_rx_byte;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          // A slot freed by this cycle's handshake can take the new word directly.
          if (!r_m_valid || w_accept) begin
            r_m_data  <= {w_rx_byte, r_lo};
            r_m_valid <= 1'b1;
          end else begin
            r_overflow <= 1'b1;
          end
        end
      end
    end
  end

  assign m_data        = r_m_data;
  assign m_valid       = r_m_valid;
  assign overflow      = r_overflow;
  assign rx_byte       = w_rx_byte;
  assign rx_byte_valid = w_rx_vld;
  assign frame_err     = w_frame_err;

endmodule
